l2_mem_responder: RTL
=====================

Name: l2_mem_responder

Overview:
Responder end of the L1-to-L2 request/response interface. It is the L2-side slave that the L1 cache controller issues refills, write-throughs and non-cacheable accesses to. It accepts one transaction at a time and services it from a local word-organised memory array. Single-beat and line-burst accesses are supported, with byte strobes on writes and error responses for illegal requests. Used as the L2/backing-store stand-in for L1 bring-up, and as a synthesizable on-chip memory slave.

Parameters:
L2_CMND_WIDTH, 2, request command width
L2_SIZE_WIDTH, 3, request size field width
L2_ADDR_WIDTH, 16, byte address width
L2_DATA_WIDTH, 32, data beat width (fixed 32 for this block)
L2_STRB_WIDTH, L2_DATA_WIDTH/8, write strobe width
BLOCK_SIZE, 32, cache line size in bytes; burst beats = BLOCK_SIZE/4 (8)
MEM_WORDS, 4096, memory depth in 32-bit words; valid byte range is 0..MEM_WORDS*4-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_val  in  1  request valid; accepted only in IDLE
req_nc  in  1  non-cacheable request
req_cmd  in  L2_CMND_WIDTH  00=RD, 01=WR, others illegal
req_size  in  L2_SIZE_WIDTH  0=byte, 1=hword, 2=word, 3=line, others illegal
req_addr  in  L2_ADDR_WIDTH  byte address
req_wdata_val  in  1  write beat valid
req_wdata  in  L2_DATA_WIDTH  write beat data
req_wstrb  in  L2_STRB_WIDTH  byte lane enables for write beat
resp_val  out  1  transaction complete (one-cycle pulse)
resp_err  out  1  error qualifier, valid with resp_val
resp_rdata_val  out  1  read beat valid
resp_rdata  out  L2_DATA_WIDTH  read beat data
busy  out  1  transaction outstanding (not IDLE)

Behaviour:
- Reset: resp_val=0, resp_err=0, resp_rdata_val=0, resp_rdata=0, busy=0, FSM=IDLE, beat counter=0. The memory array is not reset.
- Reset mid-transaction: the transaction is abandoned and no response is issued. Writes already committed persist.
- FSM states: IDLE, WR_DATA, RD_DATA, RESP_ERR, WR_DRAIN.
- Acceptance: req_val=1 in IDLE at cycle T. The block latches cmd, size, addr and nc, then evaluates legality.
- Illegal conditions: bad cmd; bad size; addr not aligned to the size (hword: addr[0]; word: addr[1:0]; line: addr mod BLOCK_SIZE); end of access beyond MEM_WORDS*4-1; req_nc=1 with size=line.
- req_val in any non-IDLE state is ignored. The initiator must not issue a new request until resp_val.
- Beat count: size 0..2 = 1 beat; size 3 = BLOCK_SIZE/4 beats. Word index = addr[ADDR_MSB:2] + beat, incrementing, no wrap (line is aligned).
- Legal read: IDLE -> RD_DATA. The RAM is read synchronously. Beat i is presented with resp_rdata_val=1 at cycle T+2+i.
  - resp_val=1, resp_err=0 coincide with the last beat.
  - Sub-word reads return the full containing word, unshifted (byte lanes as addressed).
  - resp_rdata holds its value when resp_rdata_val=0.
- Legal write: IDLE -> WR_DATA. A write beat is consumed on each cycle with req_wdata_val=1, including cycle T itself.
  - Each beat writes only the lanes whose req_wstrb bit is set, at the current word index.
  - After the last beat is consumed at cycle W: resp_val=1, resp_err=0 at W+1, then return to IDLE.
  - Gaps (req_wdata_val=0) stall the beat counter.
- Illegal read or bad cmd: IDLE -> RESP_ERR. resp_val=1, resp_err=1 at T+1, no resp_rdata_val, then IDLE.
- Illegal write (cmd=WR, other illegal condition): IDLE -> WR_DRAIN.
  - Consumes the beat count implied by size; size illegal = 1 beat.
  - Writes nothing to memory.
  - resp_val=1, resp_err=1 the cycle after the last drained beat.
- Strobe 0000 is legal: the beat is consumed and memory is unchanged.
- busy=1 from T+1 until the cycle after resp_val.
- Back-to-back: a new req_val is accepted in the cycle following resp_val at the earliest.
- req_wdata_val outside WR_DATA/WR_DRAIN, and outside the acceptance cycle of a write, is ignored.

Test Plan:
- Word write then read: WR size=2 addr=0x0040 wdata=0xDEADBEEF strb=1111 -> resp_val at T+1, err=0. Then RD size=2 addr=0x0040 -> rdata=0xDEADBEEF with rdata_val+resp_val at T+2.
- Line burst: WR size=3 addr=0x0100, 8 beats 0x11111111..0x88888888 with a 2-cycle gap after beat 3 -> resp_val one cycle after beat 8. RD size=3 addr=0x0100 -> 8 consecutive rdata_val at T+2..T+9 with matching data, resp_val on beat 8.
- Byte strobe: preload 0xAABBCCDD at 0x0008, WR size=0 addr=0x0009 wdata=0x00005500 strb=0010 -> read returns 0xAABB55DD.
- Errors: RD size=2 addr=0x0002 -> resp_val=1, resp_err=1 at T+1, no rdata_val. WR size=3 nc=1 addr=0x0100 -> 8 beats drained, resp_err=1, memory unchanged. RD addr=0x4000 (beyond MEM_WORDS=4096) -> resp_err=1. cmd=10 -> resp_err=1.
- Reset mid-burst: rst=1 during RD line beat 4 -> all outputs 0 next cycle, no resp_val. A new word RD is accepted and completes normally.
- Protocol: req_val held during an outstanding read -> ignored, exactly one resp_val. A new request accepted the cycle after resp_val -> busy toggles 1,0,1.

Source files
------------

// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - L2-side responder servicing single-beat and line-burst accesses from a word memory
module l2_mem_responder #(
  parameter int L2_CMND_WIDTH = 2,
  parameter int L2_SIZE_WIDTH = 3,
  parameter int L2_ADDR_WIDTH = 16,
  parameter int L2_DATA_WIDTH = 32,
  parameter int L2_STRB_WIDTH = L2_DATA_WIDTH/8,
  parameter int BLOCK_SIZE    = 32,
  parameter int MEM_WORDS     = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_val,
  input  logic                     req_nc,
  input  logic [L2_CMND_WIDTH-1:0] req_cmd,
  input  logic [L2_SIZE_WIDTH-1:0] req_size,
  input  logic [L2_ADDR_WIDTH-1:0] req_addr,
  input  logic                     req_wdata_val,
  input  logic [L2_DATA_WIDTH-1:0] req_wdata,
  input  logic [L2_STRB_WIDTH-1:0] req_wstrb,
  output logic                     resp_val,
  output logic                     resp_err,
  output logic                     resp_rdata_val,
  output logic [L2_DATA_WIDTH-1:0] resp_rdata,
  output logic                     busy
);

  localparam int BEATS  = BLOCK_SIZE/4;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_DATA, RESP_ERR, WR_DRAIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  base_idx;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] last_beat;

  logic [L2_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic              cmd_rd, cmd_wr, req_legal;
  logic [31:0]       addr32, req_bytes;
  logic [BEAT_W-1:0] req_last_beat;
  logic [IDX_W-1:0]  wr_idx;
  logic              mem_we;

  // Legality is judged on the live request in the acceptance cycle.
  always_comb begin
    cmd_rd    = (req_cmd == L2_CMND_WIDTH'(0));
    cmd_wr    = (req_cmd == L2_CMND_WIDTH'(1));
    addr32    = 32'(req_addr);
    req_bytes = 32'd1;
    case (req_size)
      L2_SIZE_WIDTH'(0): req_bytes = 32'd1;
      L2_SIZE_WIDTH'(1): req_bytes = 32'd2;
      L2_SIZE_WIDTH'(2): req_bytes = 32'd4;
      L2_SIZE_WIDTH'(3): req_bytes = 32'(BLOCK_SIZE);
      default:           req_bytes = 32'd1;
    endcase
    req_legal = (cmd_rd || cmd_wr)
             && (req_size <= L2_SIZE_WIDTH'(3))
             && ((addr32 & (req_bytes - 32'd1)) == 32'd0)
             && ((addr32 + req_bytes) <= 32'(MEM_WORDS*4))
             && !(req_nc && (req_size == L2_SIZE_WIDTH'(3)));
    req_last_beat = (req_size == L2_SIZE_WIDTH'(3)) ? BEAT_W'(BEATS-1) : '0;
    wr_idx = (state == IDLE) ? req_addr[IDX_W+1:2] : base_idx + IDX_W'(beat);
    mem_we = !rst && req_wdata_val
          && (((state == IDLE) && req_val && cmd_wr && req_legal)
              || ((state == WR_DATA) && !resp_val));
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < L2_STRB_WIDTH; b++) begin
        if (req_wstrb[b]) mem[wr_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Terminal states hold through the resp_val cycle so busy drops only afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat           <= '0;
      last_beat      <= '0;
      base_idx       <= '0;
      resp_val       <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata_val <= 1'b0;
      resp_rdata     <= '0;
      busy           <= 1'b0;
    end else begin
      resp_rdata_val <= 1'b0;
      case (state)
        IDLE: begin
          resp_val <= 1'b0;
          resp_err <= 1'b0;
          if (req_val) begin
            base_idx  <= req_addr[IDX_W+1:2];
            last_beat <= req_last_beat;
            beat      <= '0;
            busy      <= 1'b1;
            if (!cmd_wr && !(cmd_rd && req_legal)) begin
              state    <= RESP_ERR;
              resp_val <= 1'b1;
              resp_err <= 1'b1;
            end else if (cmd_rd) begin
              state <= RD_DATA;
            end else begin
              state <= req_legal ? WR_DATA : WR_DRAIN;
              if (req_wdata_val) begin
                if (req_last_beat == '0) begin
                  resp_val <= 1'b1;
                  resp_err <= !req_legal;
                end else begin
                  beat <= BEAT_W'(1);
                end
              end
            end
          end
        end
        RD_DATA: begin
          if (resp_val) begin
            state    <= IDLE;
            busy     <= 1'b0;
            resp_val <= 1'b0;
          end else begin
            resp_rdata     <= mem[base_idx + IDX_W'(beat)];
            resp_rdata_val <= 1'b1;
            beat           <= beat + BEAT_W'(1);
            if (beat == last_beat) resp_val <= 1'b1;
          end
        end
        WR_DATA, WR_DRAIN: begin
          if (resp_val) begin
            state    <= IDLE;
            busy     <= 1'b0;
            resp_val <= 1'b0;
            resp_err <= 1'b0;
          end else if (req_wdata_val) begin
            beat <= beat + BEAT_W'(1);
            if (beat == last_beat) begin
              resp_val <= 1'b1;
              resp_err <= (state == WR_DRAIN);
            end
          end
        end
        RESP_ERR: begin
          state    <= IDLE;
          busy     <= 1'b0;
          resp_val <= 1'b0;
          resp_err <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
